// File: rtl/ram2r1w_ctrl_pkg.sv
// Shared types for the 2R/1W table controller: controller state and
// write-requester identity used by the round-robin arbiter.
package ram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_ctrl_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } wr_req_t;

    // Requester that gets priority after `granted` wins a grant.
    function automatic wr_req_t other_req(input wr_req_t granted);
        wr_req_t nxt;
        case (granted)
            REQ_A:   nxt = REQ_B;
            REQ_B:   nxt = REQ_A;
            default: nxt = REQ_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ram2r1w_ctrl_if.sv
// Client-side bus of the 2R/1W table: two read ports, two write requesters
// and the init-done flag. The master modport is the client; the slave
// modport is the controller.
interface ram2r1w_ctrl_if #(
    parameter int WIDTH    = 64,
    parameter int LG_DEPTH = 6
);
    logic                init_done;
    logic [LG_DEPTH-1:0] rd_addr0;
    logic [LG_DEPTH-1:0] rd_addr1;
    logic [WIDTH-1:0]    rd_data0;
    logic [WIDTH-1:0]    rd_data1;
    logic                wr_valid_a;
    logic [LG_DEPTH-1:0] wr_addr_a;
    logic [WIDTH-1:0]    wr_data_a;
    logic                wr_ready_a;
    logic                wr_valid_b;
    logic [LG_DEPTH-1:0] wr_addr_b;
    logic [WIDTH-1:0]    wr_data_b;
    logic                wr_ready_b;

    modport master (
        input  init_done, rd_data0, rd_data1, wr_ready_a, wr_ready_b,
        output rd_addr0, rd_addr1,
        output wr_valid_a, wr_addr_a, wr_data_a,
        output wr_valid_b, wr_addr_b, wr_data_b
    );

    modport slave (
        output init_done, rd_data0, rd_data1, wr_ready_a, wr_ready_b,
        input  rd_addr0, rd_addr1,
        input  wr_valid_a, wr_addr_a, wr_data_a,
        input  wr_valid_b, wr_addr_b, wr_data_b
    );
endinterface

// File: rtl/ram2r1w_ctrl_ram.sv
// Raw two-read one-write RAM. Reads are registered (one cycle latency) and
// return the pre-write contents when a read collides with a same-cycle write.
// No reset on the array: the controller's init sweep establishes contents.
module ram2r1w #(
    parameter int WIDTH    = 64,
    parameter int LG_DEPTH = 6
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [LG_DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [LG_DEPTH-1:0] rd_addr0,
    input  logic [LG_DEPTH-1:0] rd_addr1,
    output logic [WIDTH-1:0]    rd_data0,
    output logic [WIDTH-1:0]    rd_data1
);
    localparam int DEPTH = 2 ** LG_DEPTH;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write plus registered reads that see the old word on collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data0 <= mem_r[rd_addr0];
        rd_data1 <= mem_r[rd_addr1];
    end
endmodule

// File: rtl/ram2r1w_ctrl.sv
// Makes one ram2r1w usable as a zero-initialised 2R/1W table: sweeps
// INIT_VALUE into every entry after reset, round-robins two write requesters
// onto the single write port, and forwards same-cycle write data to reads so
// a read issued in a write's grant cycle already sees the new value.
module ram2r1w_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               LG_DEPTH   = 6,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    ram2r1w_ctrl_if.slave bus
);
    localparam int                DEPTH    = 2 ** LG_DEPTH;
    localparam logic [LG_DEPTH:0] LAST_IDX = (LG_DEPTH + 1)'(DEPTH - 1);
    localparam logic [LG_DEPTH:0] CTR_ONE  = (LG_DEPTH + 1)'(1);

    ram_ctrl_state_t     state_r;
    logic [LG_DEPTH:0]   init_ctr_r;
    wr_req_t             rr_ptr_r;
    logic                rd_live_r;
    logic                byp0_valid_r;
    logic                byp1_valid_r;
    logic [WIDTH-1:0]    byp0_data_r;
    logic [WIDTH-1:0]    byp1_data_r;

    logic                run_s;
    logic                grant_a_s;
    logic                grant_b_s;
    logic                grant_s;
    logic                ram_wr_en_s;
    logic [LG_DEPTH-1:0] ram_wr_addr_s;
    logic [WIDTH-1:0]    ram_wr_data_s;
    logic [WIDTH-1:0]    ram_rd0_s;
    logic [WIDTH-1:0]    ram_rd1_s;

    // Writes are only accepted in RUN and never in a reset cycle.
    assign run_s   = (state_r == RUN) && !reset;
    assign grant_s = grant_a_s || grant_b_s;

    // Round-robin arbiter: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (run_s) begin
            if (bus.wr_valid_a && bus.wr_valid_b) begin
                if (rr_ptr_r == REQ_A) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else begin
                grant_a_s = bus.wr_valid_a;
                grant_b_s = bus.wr_valid_b;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Write-port mux: the init sweep owns the port in INIT, the winner in RUN.
    always_comb begin
        ram_wr_en_s   = 1'b0;
        ram_wr_addr_s = '0;
        ram_wr_data_s = '0;
        if (!reset && (state_r == INIT)) begin
            ram_wr_en_s   = 1'b1;
            ram_wr_addr_s = init_ctr_r[LG_DEPTH-1:0];
            ram_wr_data_s = INIT_VALUE;
        end else if (grant_a_s) begin
            ram_wr_en_s   = 1'b1;
            ram_wr_addr_s = bus.wr_addr_a;
            ram_wr_data_s = bus.wr_data_a;
        end else if (grant_b_s) begin
            ram_wr_en_s   = 1'b1;
            ram_wr_addr_s = bus.wr_addr_b;
            ram_wr_data_s = bus.wr_data_b;
        end else begin
            ram_wr_en_s   = 1'b0;
        end
    end

    // Init sweep FSM, round-robin pointer and per-port collision bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= INIT;
            init_ctr_r   <= '0;
            rr_ptr_r     <= REQ_A;
            rd_live_r    <= 1'b0;
            byp0_valid_r <= 1'b0;
            byp1_valid_r <= 1'b0;
            byp0_data_r  <= '0;
            byp1_data_r  <= '0;
        end else begin
            case (state_r)
                INIT: begin
                    init_ctr_r <= init_ctr_r + CTR_ONE;
                    if (init_ctr_r == LAST_IDX) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= INIT;
                    end
                end
                RUN:     state_r <= RUN;
                default: state_r <= INIT;
            endcase

            if (grant_a_s) begin
                rr_ptr_r <= other_req(REQ_A);
            end else if (grant_b_s) begin
                rr_ptr_r <= other_req(REQ_B);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end

            // A read is meaningful only if it was issued while in RUN.
            rd_live_r    <= (state_r == RUN);
            byp0_valid_r <= grant_s && (bus.rd_addr0 == ram_wr_addr_s);
            byp1_valid_r <= grant_s && (bus.rd_addr1 == ram_wr_addr_s);
            byp0_data_r  <= ram_wr_data_s;
            byp1_data_r  <= ram_wr_data_s;
        end
    end

    ram2r1w #(
        .WIDTH    (WIDTH),
        .LG_DEPTH (LG_DEPTH)
    ) u_ram (
        .clk      (clk),
        .wr_en    (ram_wr_en_s),
        .wr_addr  (ram_wr_addr_s),
        .wr_data  (ram_wr_data_s),
        .rd_addr0 (bus.rd_addr0),
        .rd_addr1 (bus.rd_addr1),
        .rd_data0 (ram_rd0_s),
        .rd_data1 (ram_rd1_s)
    );

    assign bus.init_done  = (state_r == RUN) && !reset;
    assign bus.wr_ready_a = grant_a_s;
    assign bus.wr_ready_b = grant_b_s;
    assign bus.rd_data0   = (rd_live_r && !reset) ? (byp0_valid_r ? byp0_data_r : ram_rd0_s) : '0;
    assign bus.rd_data1   = (rd_live_r && !reset) ? (byp1_valid_r ? byp1_data_r : ram_rd1_s) : '0;
endmodule
